// File: rtl/extend_arbiter.sv
// Two-requester round-robin arbiter feeding an 8-to-16-bit zero/sign extender.
// The output register holds one result word; a new grant is made only when that register is empty or being drained.
module extend_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_sign,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_sign,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_src,
    input  logic        out_ready,
    output logic [7:0]  gnt_cnt0,
    output logic [7:0]  gnt_cnt1
);

    // valid/ready: a requester byte transfers on a rising edge where valid and ready are both high;
    // the output word transfers on a rising edge where out_valid and out_ready are both high.
    logic       prio;
    logic       accept;
    logic       grant0;
    logic       grant1;
    logic [7:0] sel_data;
    logic       sel_sign;

    assign accept = !out_valid || out_ready;
    assign grant0 = accept && req0_valid && (!req1_valid || !prio);
    assign grant1 = accept && req1_valid && (!req0_valid || prio);

    // Readies are forced low while reset is held so no transfer is implied during reset.
    assign req0_ready = rst_n && grant0;
    assign req1_ready = rst_n && grant1;

    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_sign = grant1 ? req1_sign : req0_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= PRIO_INIT;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_src   <= 1'b0;
            gnt_cnt0  <= 8'h00;
            gnt_cnt1  <= 8'h00;
        end else begin
            if (grant0 || grant1) begin
                out_valid <= 1'b1;
                out_data  <= {{8{sel_data[7] && sel_sign}}, sel_data};
                out_src   <= grant1;
                prio      <= !grant1;
                if (grant1) begin
                    gnt_cnt1 <= gnt_cnt1 + 8'd1;
                end else begin
                    gnt_cnt0 <= gnt_cnt0 + 8'd1;
                end
            end else if (accept) begin
                // Drained with nothing new: data and source keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_extend_arbiter.sv
// Self-checking bench for extend_arbiter: directed scenarios plus a randomized run
// against a behavioural model with an expected-word queue.
module tb_extend_arbiter;

    localparam logic PRIO_INIT = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_sign, req0_ready;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_sign, req1_ready;
    logic [7:0]  req1_data;
    logic        out_valid, out_src, out_ready;
    logic [15:0] out_data;
    logic [7:0]  gnt_cnt0, gnt_cnt1;

    int total = 0;
    int bad = 0;

    // Behavioural model state
    logic        m_prio;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_src;
    logic [7:0]  m_cnt0, m_cnt1;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    extend_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_sign(req0_sign), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_sign(req1_sign), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    function automatic logic [15:0] extend(input logic [7:0] d, input logic s);
        if (s && d >= 8'h80) return 16'hFF00 + {8'h00, d};
        return {8'h00, d};
    endfunction

    task automatic idle_inputs;
        req0_valid = 0; req0_data = 0; req0_sign = 0;
        req1_valid = 0; req1_data = 0; req1_sign = 0;
        out_ready = 0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        req0_valid = 1; req1_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0000 || out_src !== 1'b0) begin bad++; $display("FAIL reset_data got=%h/%b exp=0000/0", out_data, out_src); end
        total++; if (gnt_cnt0 !== 8'h00 || gnt_cnt1 !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=00/00", gnt_cnt0, gnt_cnt1); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_basic;
        apply_reset();
        req0_valid = 1; req0_data = 8'h73; req0_sign = 0; out_ready = 1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL basic_ready got=%b%b exp=10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0073 || out_src !== 1'b0) begin bad++; $display("FAIL basic_out got=%b/%h/%b exp=1/0073/0", out_valid, out_data, out_src); end
        total++; if (gnt_cnt0 !== 8'd1 || gnt_cnt1 !== 8'd0) begin bad++; $display("FAIL basic_cnt got=%h/%h exp=01/00", gnt_cnt0, gnt_cnt1); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_data !== 16'h0073) begin bad++; $display("FAIL basic_drain got=%b/%h exp=0/0073", out_valid, out_data); end
    endtask

    task automatic test_extend;
        logic [7:0]  d [3] = '{8'hFF, 8'hFF, 8'h7F};
        logic        s [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] e [3] = '{16'hFFFF, 16'h00FF, 16'h007F};
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1; req1_data = d[i]; req1_sign = s[i];
            @(posedge clk); #1;
            total++; if (out_data !== e[i] || out_src !== 1'b1) begin bad++; $display("FAIL extend_%0d got=%h/%b exp=%h/1", i, out_data, out_src, e[i]); end
        end
        req1_valid = 0;
    endtask

    task automatic test_contend;
        apply_reset();
        req0_valid = 1; req0_data = 8'h11; req0_sign = 0;
        req1_valid = 1; req1_data = 8'h82; req1_sign = 1;
        out_ready = 1;
        @(posedge clk); #1;
        total++; if (out_src !== 1'b0 || out_data !== 16'h0011) begin bad++; $display("FAIL contend_first got=%b/%h exp=0/0011", out_src, out_data); end
        @(posedge clk); #1;
        total++; if (out_src !== 1'b1 || out_data !== 16'hFF82) begin bad++; $display("FAIL contend_second got=%b/%h exp=1/ff82", out_src, out_data); end
        total++; if (gnt_cnt0 !== 8'd1 || gnt_cnt1 !== 8'd1) begin bad++; $display("FAIL contend_cnt got=%h/%h exp=01/01", gnt_cnt0, gnt_cnt1); end
        out_ready = 0;
    endtask

    // Runs right after test_contend: output holds 0xFF82 from req1, req0 now preferred.
    task automatic test_stall;
        logic [7:0] last0;
        last0 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            last0 = 8'($urandom_range(0, 255));
            req0_data = last0; req0_sign = 1;
            req1_data = 8'($urandom_range(0, 255));
            #1;
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== 16'hFF82 || out_src !== 1'b1) begin bad++; $display("FAIL stall_hold_%0d got=%b/%h/%b exp=1/ff82/1", i, out_valid, out_data, out_src); end
        end
        @(negedge clk);
        out_ready = 1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL stall_release_ready got=%b%b exp=10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        total++; if (out_src !== 1'b0 || out_data !== extend(last0, 1'b1)) begin bad++; $display("FAIL stall_release_out got=%b/%h exp=0/%h", out_src, out_data, extend(last0, 1'b1)); end
    endtask

    task automatic test_wrap;
        apply_reset();
        req1_valid = 1; out_ready = 1;
        for (int i = 0; i < 256; i++) begin
            req1_data = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (i == 254) begin
                total++; if (gnt_cnt1 !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ff", gnt_cnt1); end
            end
        end
        req1_valid = 0;
        total++; if (gnt_cnt1 !== 8'h00 || gnt_cnt0 !== 8'h00) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=00/00", gnt_cnt1, gnt_cnt0); end
    endtask

    task automatic test_async_reset;
        apply_reset();
        req0_valid = 1; req0_data = 8'h9C; req0_sign = 1; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(posedge clk); #2;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hFF9C) begin bad++; $display("FAIL async_pre got=%b/%h exp=1/ff9c", out_valid, out_data); end
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || gnt_cnt0 !== 8'h00) begin bad++; $display("FAIL async_clear got=%b/%h/%h exp=0/0000/00", out_valid, out_data, gnt_cnt0); end
        out_ready = 1; req1_valid = 1; req1_data = 8'h05;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b%b exp=00", req0_ready, req1_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || gnt_cnt0 !== 8'h00 || gnt_cnt1 !== 8'h00) begin bad++; $display("FAIL async_hold got=%b/%h/%h exp=0/00/00", out_valid, gnt_cnt0, gnt_cnt1); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_src !== PRIO_INIT) begin bad++; $display("FAIL async_first got=%b/%b exp=1/%b", out_valid, out_src, PRIO_INIT); end
        idle_inputs();
    endtask

    task automatic test_random;
        int win;
        logic acc;
        logic [16:0] front;
        apply_reset();
        m_prio = PRIO_INIT; m_valid = 0; m_data = 0; m_src = 0; m_cnt0 = 0; m_cnt1 = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data = 8'($urandom_range(0, 255)); req0_sign = 1'($urandom_range(0, 1));
            req1_data = 8'($urandom_range(0, 255)); req1_sign = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = !m_valid || out_ready;
            win = -1;
            if (acc) begin
                if (req0_valid && req1_valid) win = int'(m_prio);
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
            end
            total++;
            if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, win == 0, win == 1);
            end
            if (m_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_sb_empty cyc=%0d got=%b/%h exp=none", cyc, out_src, out_data);
                end else begin
                    front = exp_q.pop_front();
                    if ({out_src, out_data} !== front) begin
                        bad++; $display("FAIL rand_sb cyc=%0d got=%b/%h exp=%b/%h", cyc, out_src, out_data, front[16], front[15:0]);
                    end
                end
            end
            @(posedge clk); #1;
            if (win == 0) begin
                m_data = extend(req0_data, req0_sign); m_src = 0; m_valid = 1; m_cnt0++; m_prio = 1;
            end else if (win == 1) begin
                m_data = extend(req1_data, req1_sign); m_src = 1; m_valid = 1; m_cnt1++; m_prio = 0;
            end else if (acc) begin
                m_valid = 0;
            end
            if (win >= 0) exp_q.push_back({m_src, m_data});
            total++;
            if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src || gnt_cnt0 !== m_cnt0 || gnt_cnt1 !== m_cnt1) begin
                bad++; $display("FAIL rand_out cyc=%0d got=%b/%h/%b/%h/%h exp=%b/%h/%b/%h/%h", cyc,
                                out_valid, out_data, out_src, gnt_cnt0, gnt_cnt1, m_valid, m_data, m_src, m_cnt0, m_cnt1);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_extend();
        test_contend();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
